// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I datapath.
// Moore-style sequencing with a memory-ready stall handshake.
module multicycle_controller #(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       LSB,
  input  logic       memReady,
  output logic       PCWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       IRWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] immSrc,
  output logic       regWrite,
  output logic       instrDone
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXECR    = 4'd2,
    S_EXECI    = 4'd3,
    S_ALUWB    = 4'd4,
    S_MEMADR   = 4'd5,
    S_MEMREAD  = 4'd6,
    S_MEMWB    = 4'd7,
    S_MEMWRITE = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t state_q, state_d;
  logic   rdy;

  assign rdy = (MEM_WAIT_EN != 0) ? memReady : 1'b1;

  // State register; reset lands in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and output decode
  always_comb begin
    state_d    = S_FETCH;
    PCWrite    = 1'b0;
    adrSrc     = 1'b0;
    memWrite   = 1'b0;
    IRWrite    = 1'b0;
    resultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    immSrc     = IMM_I;
    regWrite   = 1'b0;
    instrDone  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        resultSrc = 2'b10;
        IRWrite   = rdy;
        PCWrite   = rdy;
        state_d   = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        immSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_R:    state_d = S_EXECR;
          OP_I:    state_d = S_EXECI;
          OP_LD,
          OP_ST:   state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          OP_JAL:  state_d = S_JAL;
          OP_JALR: state_d = S_JALR1;
          OP_LUI:  state_d = S_LUI;
          default: begin
            state_d   = S_FETCH;
            instrDone = 1'b1;
          end
        endcase
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        state_d = S_ALUWB;
        case ({func7, func3})
          10'b0100000_000: ALUControl = ALU_SUB;
          10'b0000000_111: ALUControl = ALU_AND;
          10'b0000000_110: ALUControl = ALU_OR;
          10'b0000000_010: ALUControl = ALU_SLT;
          default:         ALUControl = ALU_ADD;
        endcase
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
        case (func3)
          3'b100:  ALUControl = ALU_XOR;
          3'b110:  ALUControl = ALU_OR;
          3'b010:  ALUControl = ALU_SLT;
          default: ALUControl = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        immSrc  = (op == OP_ST) ? IMM_S : IMM_I;
        state_d = (op == OP_ST) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrSrc  = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc    = 1'b1;
        memWrite  = 1'b1;
        instrDone = rdy;
        state_d   = rdy ? S_FETCH : S_MEMWRITE;
      end
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        instrDone = 1'b1;
        case (func3)
          3'b000: begin
            ALUControl = ALU_SUB;
            PCWrite    = zero;
          end
          3'b001: begin
            ALUControl = ALU_SUB;
            PCWrite    = ~zero;
          end
          3'b100: begin
            ALUControl = ALU_SLT;
            PCWrite    = LSB;
          end
          3'b101: begin
            ALUControl = ALU_SLT;
            PCWrite    = ~LSB;
          end
          default: PCWrite = 1'b0;
        endcase
      end
      S_JAL, S_JALR2: begin
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        state_d = S_ALUWB;
      end
      S_JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JALR2;
      end
      S_LUI: begin
        immSrc    = IMM_U;
        resultSrc = 2'b11;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for the multi-cycle controller.
// Reference model works from named instruction steps.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [2:0] imm;
    logic       rw;
    logic       done;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       LSB;
  logic       memReady;
  logic       PCWrite, adrSrc, memWrite, IRWrite;
  logic [1:0] resultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, immSrc;
  logic       regWrite, instrDone;

  ctl_t  obs;
  ctl_t  exp_c;
  int    checks = 0;
  int    errors = 0;
  string plan[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op),
    .func3(func3), .func7(func7),
    .zero(zero), .LSB(LSB),
    .memReady(memReady),
    .PCWrite(PCWrite), .adrSrc(adrSrc),
    .memWrite(memWrite), .IRWrite(IRWrite),
    .resultSrc(resultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .immSrc(immSrc), .regWrite(regWrite),
    .instrDone(instrDone)
  );

  assign obs = {PCWrite, adrSrc, memWrite, IRWrite,
                resultSrc, ALUSrcA, ALUSrcB,
                ALUControl, immSrc, regWrite, instrDone};

  function automatic bit legal(input logic [6:0] o);
    return o == 7'b0110011 || o == 7'b0010011 ||
           o == 7'b0000011 || o == 7'b0100011 ||
           o == 7'b1100011 || o == 7'b1101111 ||
           o == 7'b1100111 || o == 7'b0110111;
  endfunction

  // Expected control word for a named step
  function automatic ctl_t ref_out(
    input string s, input logic [6:0] o,
    input logic [2:0] f3, input logic [6:0] f7,
    input logic z, input logic l, input logic r);
    ctl_t c;
    c = '0;
    if (s == "FETCH") begin
      c.sb = 2; c.rs = 2; c.irw = r; c.pcw = r;
    end else if (s == "DECODE") begin
      c.sa = 1; c.sb = 1;
      c.imm = (o == 7'b1101111) ? 3 : 2;
      c.done = !legal(o);
    end else if (s == "EXECR") begin
      c.sa = 2;
      if (f7 == 7'h20 && f3 == 0) c.alu = 1;
      else if (f7 == 0 && f3 == 7) c.alu = 2;
      else if (f7 == 0 && f3 == 6) c.alu = 3;
      else if (f7 == 0 && f3 == 2) c.alu = 5;
    end else if (s == "EXECI") begin
      c.sa = 2; c.sb = 1;
      if (f3 == 4) c.alu = 4;
      else if (f3 == 6) c.alu = 3;
      else if (f3 == 2) c.alu = 5;
    end else if (s == "ALUWB") begin
      c.rw = 1; c.done = 1;
    end else if (s == "MEMADR") begin
      c.sa = 2; c.sb = 1;
      c.imm = (o == 7'b0100011) ? 1 : 0;
    end else if (s == "MEMREAD") begin
      c.adr = 1;
    end else if (s == "MEMWB") begin
      c.rs = 1; c.rw = 1; c.done = 1;
    end else if (s == "MEMWRITE") begin
      c.adr = 1; c.mw = 1; c.done = r;
    end else if (s == "BRANCH") begin
      c.sa = 2; c.done = 1;
      case (f3)
        0: begin c.alu = 1; c.pcw = z;  end
        1: begin c.alu = 1; c.pcw = !z; end
        4: begin c.alu = 5; c.pcw = l;  end
        5: begin c.alu = 5; c.pcw = !l; end
        default: c.pcw = 0;
      endcase
    end else if (s == "JAL" || s == "JALR2") begin
      c.pcw = 1; c.sa = 1; c.sb = 2;
    end else if (s == "JALR1") begin
      c.sa = 2; c.sb = 1;
    end else if (s == "LUI") begin
      c.imm = 4; c.rs = 3; c.rw = 1; c.done = 1;
    end
    return c;
  endfunction

  // Step list an opcode walks through
  task automatic build_plan(input logic [6:0] o);
    plan = {"FETCH", "DECODE"};
    case (o)
      7'b0110011: plan = {plan, "EXECR", "ALUWB"};
      7'b0010011: plan = {plan, "EXECI", "ALUWB"};
      7'b0000011: plan = {plan, "MEMADR", "MEMREAD", "MEMWB"};
      7'b0100011: plan = {plan, "MEMADR", "MEMWRITE"};
      7'b1100011: plan = {plan, "BRANCH"};
      7'b1101111: plan = {plan, "JAL", "ALUWB"};
      7'b1100111: plan = {plan, "JALR1", "JALR2", "ALUWB"};
      7'b0110111: plan = {plan, "LUI"};
      default: ;
    endcase
  endtask

  task automatic check_now(input string s, input logic r);
    exp_c = ref_out(s, op, func3, func7, zero, LSB, r);
    checks++;
    assert (obs === exp_c) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", s, obs, exp_c);
    end
  endtask

  // One cycle in step s; entered just after a rising edge
  task automatic cyc(input string s, input logic r);
    memReady = r;
    @(negedge clk);
    check_now(s, r);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(
    input logic [6:0] o, input logic [2:0] f3,
    input logic [6:0] f7, input logic z, input logic l,
    input int wf, input int wm);
    int n;
    op = o; func3 = f3; func7 = f7;
    zero = z; LSB = l;
    build_plan(o);
    foreach (plan[i]) begin
      if (plan[i] == "FETCH") n = wf;
      else if (plan[i] == "MEMREAD" ||
               plan[i] == "MEMWRITE") n = wm;
      else n = -1;
      if (n < 0) begin
        cyc(plan[i], 1'($urandom_range(0, 1)));
      end else begin
        for (int k = 0; k < n; k++) cyc(plan[i], 1'b0);
        cyc(plan[i], 1'b1);
      end
    end
  endtask

  logic [6:0] ops [9];

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011,
            7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b1111111};
    rst_n = 1'b0; memReady = 1'b0;
    op = '0; func3 = '0; func7 = '0;
    zero = 1'b0; LSB = 1'b0;
    #3 check_now("FETCH", 1'b0);
    @(posedge clk); #1;
    check_now("FETCH", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr(7'b0110011, 3'd0, 7'h00, 0, 0, 0, 0);
    run_instr(7'b0000011, 3'd2, 7'h00, 0, 0, 2, 3);
    run_instr(7'b0100011, 3'd2, 7'h00, 0, 0, 0, 1);
    run_instr(7'b1100011, 3'd0, 7'h00, 1, 0, 0, 0);
    run_instr(7'b1100011, 3'd1, 7'h00, 1, 0, 0, 0);
    run_instr(7'b1100011, 3'd5, 7'h00, 0, 0, 0, 0);
    run_instr(7'b1101111, 3'd0, 7'h00, 0, 0, 0, 0);
    run_instr(7'b1100111, 3'd0, 7'h00, 0, 0, 0, 0);
    run_instr(7'b0110111, 3'd0, 7'h00, 0, 0, 0, 0);
    run_instr(7'b1111111, 3'd0, 7'h00, 0, 0, 0, 0);

    // reset pulled while a store is waiting on memory
    op = 7'b0100011; func3 = 3'd2; func7 = '0;
    cyc("FETCH", 1'b1);
    cyc("DECODE", 1'b1);
    cyc("MEMADR", 1'b0);
    memReady = 1'b0;
    @(negedge clk);
    check_now("MEMWRITE", 1'b0);
    #1 rst_n = 1'b0;
    #1 check_now("FETCH", 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr(7'b0010011, 3'd4, 7'h00, 0, 0, 1, 0);

    for (int t = 0; t < 80; t++) begin
      logic [6:0] f7r;
      case ($urandom_range(0, 2))
        0:       f7r = 7'h00;
        1:       f7r = 7'h20;
        default: f7r = 7'($urandom);
      endcase
      run_instr(ops[$urandom_range(0, 8)],
                3'($urandom), f7r,
                1'($urandom), 1'($urandom),
                $urandom_range(0, 3),
                $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style FSM controller for the multi-cycle RV32I datapath: a single shared ALU, one unified instruction/data memory, and registers IR, oldPC, A, B, ALUOut and Data.
- Sequences each instruction over 3–5 states.
- Uses the same opcode set and the same ALUControl/immSrc encodings as the single-cycle control path.
- Adds a memory-ready handshake so fetch and data accesses can stall.

Parameters:
- MEM_WAIT_EN, 1, when 1 the memory states wait for memReady; when 0 memReady is ignored and treated as 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op  input  7  IR[6:0].
- func3  input  3  IR[14:12].
- func7  input  7  IR[31:25].
- zero  input  1  ALU result == 0.
- LSB  input  1  ALU result bit 0 (SLT outcome).
- memReady  input  1  memory access completes this cycle.
- PCWrite  output  1  PC load enable.
- adrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memWrite  output  1  memory write enable.
- IRWrite  output  1  IR and oldPC load enable.
- resultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU result, 11 = immediate.
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = oldPC, 10 = A.
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = immediate, 10 = constant 4.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- immSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U.
- regWrite  output  1  register file write enable.
- instrDone  output  1  one-cycle pulse in the final state of each instruction.

Behaviour:
- State register, 4 bits, async reset to FETCH while rst_n = 0. All outputs are decoded combinationally from state, op, func3/func7, zero, LSB and memReady.
- Default value of every output in every state is 0, unless listed below.
- During reset the state is FETCH. With memReady = 0, all write enables and instrDone are therefore 0.
- Reset asserted mid-instruction abandons it immediately; memWrite drops asynchronously.
- FETCH:
  - ALUSrcB = 10, resultSrc = 10, adrSrc = 0, ALUControl = add.
  - IRWrite = PCWrite = memReady.
  - Next state: DECODE if memReady, else FETCH.
- DECODE:
  - ALUSrcA = 01, ALUSrcB = 01, add; produces the target oldPC + imm in ALUOut.
  - immSrc = J if op = JAL (1101111), else B.
  - Next state by op:
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 0000011 / 0100011 → MEMADR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR1
    - 0110111 → LUI
    - any other op → FETCH with instrDone = 1 (NOP; PC was already advanced).
- EXECR:
  - ALUSrcA = 10, ALUSrcB = 00.
  - {func7, func3}: add 0000000_000, sub 0100000_000, and 0000000_111, or 0000000_110, slt 0000000_010.
  - Any other combination → add.
  - Next state: ALUWB.
- EXECI:
  - ALUSrcA = 10, ALUSrcB = 01, immSrc = I.
  - func3: 000 add, 100 xor, 110 or, 010 slt; other → add.
  - Next state: ALUWB.
- ALUWB: resultSrc = 00, regWrite = 1, instrDone = 1. Next state: FETCH.
- MEMADR:
  - ALUSrcA = 10, ALUSrcB = 01, add.
  - immSrc = S for a store, I for a load.
  - Next state: MEMWRITE for a store, else MEMREAD.
- MEMREAD: adrSrc = 1. Stays in MEMREAD until memReady, then MEMWB.
- MEMWB: resultSrc = 01, regWrite = 1, instrDone = 1. Next state: FETCH.
- MEMWRITE:
  - adrSrc = 1; memWrite = 1 for every cycle spent in the state.
  - instrDone = memReady.
  - Stays in MEMWRITE until memReady, then FETCH.
- BRANCH:
  - ALUSrcA = 10, ALUSrcB = 00, resultSrc = 00, instrDone = 1.
  - func3 000 beq: ALUControl = sub, PCWrite = zero.
  - func3 001 bne: ALUControl = sub, PCWrite = !zero.
  - func3 100 blt: ALUControl = slt, PCWrite = LSB.
  - func3 101 bge: ALUControl = slt, PCWrite = !LSB.
  - Any other func3: PCWrite = 0.
  - Next state: FETCH.
- JAL: PCWrite = 1, resultSrc = 00, ALUSrcA = 01, ALUSrcB = 10, add. Next state: ALUWB, which writes oldPC + 4 to rd.
- JALR1: ALUSrcA = 10, ALUSrcB = 01, immSrc = I, add. Next state: JALR2.
- JALR2: identical outputs to JAL. Next state: ALUWB.
- LUI: immSrc = U, resultSrc = 11, regWrite = 1, instrDone = 1. Next state: FETCH.
- Unused state encodings → FETCH on the next clock, with all outputs 0.
- memReady is sampled only in FETCH, MEMREAD and MEMWRITE. If memReady is already high on entry, there is no wait cycle.

Test Plan:
- add x3,x1,x2 with memReady = 1 → states FETCH, DECODE, EXECR, ALUWB (4 cycles). ALUWB: regWrite = 1, resultSrc = 00, instrDone = 1. EXECR: ALUControl = 000.
- lw, with memReady = 0 for 2 cycles in FETCH and 3 cycles in MEMREAD → 10 cycles total.
  - IRWrite pulses only in the ready FETCH cycle.
  - MEMWB: resultSrc = 01, regWrite = 1.
- sw, with memReady low for 1 cycle in MEMWRITE → memWrite = 1 for 2 cycles, adrSrc = 1, MEMADR immSrc = 001, instrDone only on the ready cycle.
- beq with zero = 1, then bne with zero = 1, then bge with LSB = 0:
  - PCWrite = 1, 0, 1 respectively in BRANCH.
  - ALUControl = 001, 001, 101.
  - Each instruction takes 3 cycles.
- jal, jalr and lui:
  - jal: 4 cycles; PCWrite in JAL, and DECODE immSrc = 011.
  - jalr: 5 cycles; PCWrite in JALR2.
  - lui: 3 cycles; resultSrc = 11, immSrc = 100.
- Edge cases:
  - rst_n pulled low during MEMWRITE → memWrite = 0 immediately; state FETCH after release.
  - Illegal op 1111111 → return to FETCH after DECODE with instrDone = 1 and no write enables.
